// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one pipeline-stage boundary: upstream offer side and downstream head side.
// The stage itself uses the slave view; whatever feeds and drains it uses the master view.
interface pipe_stage_skid_if #(
    parameter int IR_W = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [IR_W-1:0] in_ir;
    logic [PC_W-1:0] in_pc4;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [IR_W-1:0] out_ir;
    logic [PC_W-1:0] out_pc4;
    logic [PC_W-1:0] out_pc8;

    modport master (
        output in_valid, in_ir, in_pc4, flush, out_ready,
        input  in_ready, out_valid, out_ir, out_pc4, out_pc8
    );

    modport slave (
        input  in_valid, in_ir, in_pc4, flush, out_ready,
        output in_ready, out_valid, out_ir, out_pc4, out_pc8
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a two-entry skid buffer, synchronous flush and a saturating
// stall counter. The state encoding doubles as the occupancy count.
//
//   state | meaning
//   EMPTY | nothing held, outputs masked
//   ONE   | head (main) valid, skid free
//   TWO   | head and skid valid, upstream held off
module pipe_stage_skid #(
    parameter int          IR_W   = 32,
    parameter int          PC_W   = 32,
    parameter logic [31:0] NOP_IR = 32'h0000_0000,
    parameter int          CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_stage_skid_if.slave     bus,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);
    localparam logic [IR_W-1:0] NOP_V = IR_W'(NOP_IR);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [IR_W-1:0]   main_ir_q, main_ir_d;
    logic [PC_W-1:0]   main_pc4_q, main_pc4_d;
    logic [IR_W-1:0]   skid_ir_q, skid_ir_d;
    logic [PC_W-1:0]   skid_pc4_q, skid_pc4_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic out_valid;
    logic in_fire;
    logic out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = bus.in_valid & in_ready_q & ~bus.flush;
    assign out_fire  = out_valid & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        main_ir_d   = main_ir_q;
        main_pc4_d  = main_pc4_q;
        skid_ir_d   = skid_ir_q;
        skid_pc4_d  = skid_pc4_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d    = ONE;
                    main_ir_d  = bus.in_ir;
                    main_pc4_d = bus.in_pc4;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_ir_d  = bus.in_ir;
                    main_pc4_d = bus.in_pc4;
                end else if (in_fire) begin
                    state_d    = TWO;
                    skid_ir_d  = bus.in_ir;
                    skid_pc4_d = bus.in_pc4;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d    = ONE;
                    main_ir_d  = skid_ir_q;
                    main_pc4_d = skid_pc4_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush wins over every transition; a same-cycle out_fire was already sampled downstream.
        if (bus.flush) begin
            state_d = EMPTY;
        end

        if (out_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_ir_q   <= '0;
            main_pc4_q  <= '0;
            skid_ir_q   <= '0;
            skid_pc4_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ir_q   <= main_ir_d;
            main_pc4_q  <= main_pc4_d;
            skid_ir_q   <= skid_ir_d;
            skid_pc4_q  <= skid_pc4_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_ir    = out_valid ? main_ir_q : NOP_V;
    assign bus.out_pc4   = out_valid ? main_pc4_q : '0;
    assign bus.out_pc8   = out_valid ? (main_pc4_q + PC_W'(4)) : '0;
    assign occupancy     = state_q;
    assign stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, flush, PC wrap,
// counter saturation and asynchronous reset with a full buffer.
module tb_pipe_stage_skid;
    localparam int          IR_W   = 32;
    localparam int          PC_W   = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;
    int               n_cmp = 0;
    int               n_bad = 0;

    pipe_stage_skid_if #(.IR_W(IR_W), .PC_W(PC_W)) bus ();

    pipe_stage_skid #(
        .IR_W(IR_W), .PC_W(PC_W), .NOP_IR(NOP_IR), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc4);
        bus.in_valid = v;
        bus.in_ir    = ir;
        bus.in_pc4   = pc4;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || occupancy !== 2'd0 || stall_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: valid=%b ready=%b occ=%0d stall=%0d, want 0 1 0 0",
                     bus.out_valid, bus.in_ready, occupancy, stall_cnt);
        end
        n_cmp++;
        if (bus.out_ir !== NOP_IR || bus.out_pc4 !== 32'h0 || bus.out_pc8 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: ir=%h pc4=%h pc8=%h, want %h 0 0", bus.out_ir, bus.out_pc4, bus.out_pc8, NOP_IR);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || occupancy !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_release: valid=%b ready=%b occ=%0d, want 0 1 0", bus.out_valid, bus.in_ready, occupancy);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [4];
        pcs[0] = 32'h3004; pcs[1] = 32'h3008; pcs[2] = 32'h300C; pcs[3] = 32'h3010;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i + 1), pcs[i]);
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_ir !== 32'(i + 1) || bus.out_pc4 !== pcs[i] ||
                bus.out_pc8 !== pcs[i] + 32'd4) begin
                n_bad++;
                $display("FAIL stream_%0d: valid=%b ir=%h pc4=%h pc8=%h, want 1 %h %h %h",
                         i, bus.out_valid, bus.out_ir, bus.out_pc4, bus.out_pc8, 32'(i + 1), pcs[i], pcs[i] + 32'd4);
            end
            n_cmp++;
            if (occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_occ_%0d: occ=%0d ready=%b, want 1 1", i, occupancy, bus.in_ready);
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL stream_drain: valid=%b occ=%0d stall=%0d, want 0 0 0", bus.out_valid, occupancy, stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hA, 32'h100);
        tick();
        n_cmp++;
        if (occupancy !== 2'd1 || bus.in_ready !== 1'b1 || bus.out_ir !== 32'hA || stall_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL bp_a: occ=%0d ready=%b ir=%h stall=%0d, want 1 1 a 0", occupancy, bus.in_ready, bus.out_ir, stall_cnt);
        end
        drive(1'b1, 32'hB, 32'h104);
        tick();
        n_cmp++;
        if (occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_ir !== 32'hA || stall_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL bp_b: occ=%0d ready=%b ir=%h stall=%0d, want 2 0 a 1", occupancy, bus.in_ready, bus.out_ir, stall_cnt);
        end
        drive(1'b1, 32'hC, 32'h108);
        tick();
        tick();
        n_cmp++;
        if (occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_ir !== 32'hA || stall_cnt !== 4'd3) begin
            n_bad++;
            $display("FAIL bp_hold: occ=%0d ready=%b ir=%h stall=%0d, want 2 0 a 3", occupancy, bus.in_ready, bus.out_ir, stall_cnt);
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.out_ir !== 32'hB || bus.out_pc4 !== 32'h104 || occupancy !== 2'd1 || bus.in_ready !== 1'b1 || stall_cnt !== 4'd3) begin
            n_bad++;
            $display("FAIL bp_deliver_b: ir=%h pc4=%h occ=%0d ready=%b stall=%0d, want b 104 1 1 3",
                     bus.out_ir, bus.out_pc4, occupancy, bus.in_ready, stall_cnt);
        end
        tick();
        n_cmp++;
        if (bus.out_ir !== 32'hC || bus.out_pc8 !== 32'h10C || occupancy !== 2'd1) begin
            n_bad++;
            $display("FAIL bp_deliver_c: ir=%h pc8=%h occ=%0d, want c 10c 1", bus.out_ir, bus.out_pc8, occupancy);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_bad++;
            $display("FAIL bp_drain: valid=%b occ=%0d, want 0 0", bus.out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hE, 32'h200);
        tick();
        drive(1'b1, 32'hF, 32'h204);
        tick();
        n_cmp++;
        if (occupancy !== 2'd2 || stall_cnt !== 4'd4) begin
            n_bad++;
            $display("FAIL flush_fill: occ=%0d stall=%0d, want 2 4", occupancy, stall_cnt);
        end
        drive(1'b1, 32'hD, 32'h208);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_ir !== NOP_IR || bus.out_pc4 !== 32'h0 || bus.out_pc8 !== 32'h0) begin
            n_bad++;
            $display("FAIL flush_mask: valid=%b ir=%h pc4=%h pc8=%h, want 0 %h 0 0",
                     bus.out_valid, bus.out_ir, bus.out_pc4, bus.out_pc8, NOP_IR);
        end
        n_cmp++;
        if (occupancy !== 2'd0 || bus.in_ready !== 1'b1 || stall_cnt !== 4'd5) begin
            n_bad++;
            $display("FAIL flush_state: occ=%0d ready=%b stall=%0d, want 0 1 5", occupancy, bus.in_ready, stall_cnt);
        end
        drive(1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.out_ir !== NOP_IR) begin
                n_bad++;
                $display("FAIL flush_no_d_%0d: valid=%b ir=%h, want 0 %h", i, bus.out_valid, bus.out_ir, NOP_IR);
            end
        end
    endtask

    task automatic test_pc_wrap();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h7, 32'hFFFF_FFFC);
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_pc4 !== 32'hFFFF_FFFC || bus.out_pc8 !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL pc_wrap: valid=%b pc4=%h pc8=%h, want 1 fffffffc 00000000", bus.out_valid, bus.out_pc4, bus.out_pc8);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_saturation();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h55, 32'h400);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_cmp++;
            if (stall_cnt !== ((5 + i > 15) ? 4'd15 : 4'(5 + i))) begin
                n_bad++;
                $display("FAIL sat_%0d: stall=%0d, want %0d", i, stall_cnt, (5 + i > 15) ? 15 : 5 + i);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || stall_cnt !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_hold: valid=%b stall=%0d, want 0 15", bus.out_valid, stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h91, 32'h500);
        tick();
        drive(1'b1, 32'h92, 32'h504);
        tick();
        n_cmp++;
        if (occupancy !== 2'd2) begin
            n_bad++;
            $display("FAIL rmid_fill: occ=%0d, want 2", occupancy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_ir !== NOP_IR || bus.in_ready !== 1'b1 || occupancy !== 2'd0 || stall_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL rmid_async: valid=%b ir=%h ready=%b occ=%0d stall=%0d, want 0 %h 1 0 0",
                     bus.out_valid, bus.out_ir, bus.in_ready, occupancy, stall_cnt, NOP_IR);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || occupancy !== 2'd0 || bus.out_pc8 !== 32'h0 || stall_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL rmid_release: valid=%b occ=%0d pc8=%h stall=%0d, want 0 0 0 0",
                     bus.out_valid, occupancy, bus.out_pc8, stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_pc_wrap();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
